// File: rtl/traffic_fsm_if.sv
// Signal bundle between the traffic controller and its environment
// (sensors, interval timer, lamp drivers).
//   sensor          side-street vehicle present (synchronized level)
//   walk_request    pedestrian request (pulse or level, debounced)
//   expired         interval timer done, held until the next start_timer
//   start_timer     one-cycle pulse launching the interval timer
//   interval_select 00 BASE, 01 EXT, 10 YEL (11 never driven)
//   main_lights     {red,yellow,green} for the main street
//   side_lights     {red,yellow,green} for the side street
//   walk_lamp       pedestrian walk indication
// master: the controller; slave: the environment driving the inputs.
interface traffic_fsm_if;
  logic       sensor;
  logic       walk_request;
  logic       expired;
  logic       start_timer;
  logic [1:0] interval_select;
  logic [2:0] main_lights;
  logic [2:0] side_lights;
  logic       walk_lamp;

  modport master (
    input  sensor, walk_request, expired,
    output start_timer, interval_select, main_lights, side_lights, walk_lamp
  );

  modport slave (
    output sensor, walk_request, expired,
    input  start_timer, interval_select, main_lights, side_lights, walk_lamp
  );
endinterface

// File: rtl/traffic_fsm.sv
// Traffic light controller for a main/side street crossing with a
// pedestrian phase. Every output is registered and decoded from the
// next state, so outputs reflect a transition right after the edge
// that takes it.
//   clk          system clock, rising edge
//   reset_global synchronous, active-high reset
//   bus          traffic_fsm_if.master (inputs sensor, walk_request,
//                expired; outputs start_timer, interval_select,
//                main_lights, side_lights, walk_lamp)
module traffic_fsm (
  input  logic          clk,
  input  logic          reset_global,
  traffic_fsm_if.master bus
);

  typedef enum logic [2:0] {
    MG     = 3'd0,
    MG_EXT = 3'd1,
    MY     = 3'd2,
    WALK   = 3'd3,
    SG     = 3'd4,
    SG_EXT = 3'd5,
    SY     = 3'd6
  } state_t;

  localparam logic [1:0] INT_BASE = 2'b00;
  localparam logic [1:0] INT_EXT  = 2'b01;
  localparam logic [1:0] INT_YEL  = 2'b10;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  state_t     state, state_next;
  logic       walk_latch, walk_latch_next;
  // Cleared by reset; its first set cycle issues the post-reset timer start.
  logic       armed;
  logic       advance;

  logic       start_q, start_next;
  logic [1:0] isel_q, isel_next;
  logic [2:0] main_q, main_next;
  logic [2:0] side_q, side_next;
  logic       lamp_q, lamp_next;

  always_comb begin
    state_next = state;
    // A stale expired from the previous interval is visible while
    // start_timer is high, so it only counts from the cycle after.
    advance    = bus.expired && !start_q && armed;

    case (state)
      MG:      if (advance) state_next = bus.sensor ? MY : MG_EXT;
      MG_EXT:  if (advance) state_next = MY;
      MY:      if (advance) state_next = walk_latch ? WALK : SG;
      WALK:    if (advance) state_next = SG;
      SG:      if (advance) state_next = bus.sensor ? SG_EXT : SY;
      SG_EXT:  if (advance) state_next = SY;
      SY:      if (advance) state_next = MG;
      default: state_next = MG;
    endcase

    // Every transition changes state, so a state change is the entry
    // cycle; illegal encodings land here as well.
    start_next = !armed || (state_next != state);

    // A request in the WALK-entry cycle wins over the clear.
    walk_latch_next = bus.walk_request
                    | (walk_latch & ~(state_next == WALK && state != WALK));

    isel_next = INT_BASE;
    main_next = LT_GRN;
    side_next = LT_RED;
    lamp_next = 1'b0;
    case (state_next)
      MG_EXT: isel_next = INT_EXT;
      MY: begin
        isel_next = INT_YEL;
        main_next = LT_YEL;
      end
      WALK: begin
        isel_next = INT_EXT;
        main_next = LT_RED;
        lamp_next = 1'b1;
      end
      SG: begin
        main_next = LT_RED;
        side_next = LT_GRN;
      end
      SG_EXT: begin
        isel_next = INT_EXT;
        main_next = LT_RED;
        side_next = LT_GRN;
      end
      SY: begin
        isel_next = INT_YEL;
        main_next = LT_RED;
        side_next = LT_YEL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_global) begin
      state      <= MG;
      walk_latch <= 1'b0;
      armed      <= 1'b0;
      start_q    <= 1'b0;
      isel_q     <= INT_BASE;
      main_q     <= LT_GRN;
      side_q     <= LT_RED;
      lamp_q     <= 1'b0;
    end else begin
      state      <= state_next;
      walk_latch <= walk_latch_next;
      armed      <= 1'b1;
      start_q    <= start_next;
      isel_q     <= isel_next;
      main_q     <= main_next;
      side_q     <= side_next;
      lamp_q     <= lamp_next;
    end
  end

  assign bus.start_timer     = start_q;
  assign bus.interval_select = isel_q;
  assign bus.main_lights     = main_q;
  assign bus.side_lights     = side_q;
  assign bus.walk_lamp       = lamp_q;

endmodule
